// File: rtl/sequence_detector_param.sv
// rtl/sequence_detector_param.sv - parametrised serial bit-pattern detector with loadable pattern and saturating match counter
module sequence_detector_param #(
    parameter int                   PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0]   PAT_RST = 4'b1011,
    parameter int                   CNT_W   = 8
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               en_i,
    input  logic               x_i,
    input  logic               load_i,
    input  logic [PAT_LEN-1:0] pattern_i,
    input  logic               overlap_i,
    input  logic               clr_i,
    output logic               y_o,
    output logic [CNT_W-1:0]   match_count_o,
    output logic               count_sat_o
);

    localparam int                 FILL_W    = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(PAT_LEN);
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

    // FILLING until a full pattern's worth of bits has been collected, then ARMED
    typedef enum logic {
        FILLING = 1'b0,
        ARMED   = 1'b1
    } mode_t;

    logic [PAT_LEN-1:0] pat_q,  pat_d;
    logic [PAT_LEN-1:0] hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               y_q,    y_d;
    logic [CNT_W-1:0]   cnt_q,  cnt_d;
    logic               sat_q,  sat_d;

    mode_t              mode;
    logic [PAT_LEN-1:0] nh;
    logic [FILL_W-1:0]  nf;
    logic               match;

    // State registers; reset restores the default pattern and clears all history
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pat_q  <= PAT_RST;
            hist_q <= '0;
            fill_q <= '0;
            y_q    <= 1'b0;
            cnt_q  <= '0;
            sat_q  <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            y_q    <= y_d;
            cnt_q  <= cnt_d;
            sat_q  <= sat_d;
        end
    end

    // Next-state: Load beats sampling; Clr beats a same-cycle counter increment
    always_comb begin
        pat_d  = pat_q;
        hist_d = hist_q;
        fill_d = fill_q;
        y_d    = 1'b0;
        cnt_d  = cnt_q;
        sat_d  = sat_q;
        match  = 1'b0;

        mode = (fill_q == FILL_FULL) ? ARMED : FILLING;
        nh   = {hist_q[PAT_LEN-2:0], x_i};
        nf   = (mode == ARMED) ? FILL_FULL : fill_q + FILL_W'(1);

        if (load_i) begin
            pat_d  = pattern_i;
            hist_d = '0;
            fill_d = '0;
        end else if (en_i) begin
            match  = (nf == FILL_FULL) && (nh == pat_q);
            hist_d = nh;
            y_d    = match;
            if (match) begin
                // Overlap keeps the tail bits usable for the next occurrence
                fill_d = overlap_i ? FILL_FULL : '0;
            end else begin
                fill_d = nf;
            end
        end

        if (match && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (cnt_d == CNT_MAX) begin
            sat_d = 1'b1;
        end
        if (clr_i) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end
    end

    assign y_o           = y_q;
    assign match_count_o = cnt_q;
    assign count_sat_o   = sat_q;

endmodule

// File: tb/tb_sequence_detector_param.sv
// tb/tb_sequence_detector_param.sv - self-checking bench for sequence_detector_param
module tb_sequence_detector_param;

    logic       clk;
    logic       rst_n;
    logic       en, x, load, overlap, clr;
    logic [3:0] pattern;

    logic       y8, sat8, y2, sat2;
    logic [7:0] cnt8;
    logic [1:0] cnt2;

    int checks = 0;
    int passed = 0;

    sequence_detector_param dut (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .x_i(x), .load_i(load),
        .pattern_i(pattern), .overlap_i(overlap), .clr_i(clr),
        .y_o(y8), .match_count_o(cnt8), .count_sat_o(sat8)
    );

    sequence_detector_param #(.PAT_LEN(4), .PAT_RST(4'b1011), .CNT_W(2)) dut_w2 (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .x_i(x), .load_i(load),
        .pattern_i(pattern), .overlap_i(overlap), .clr_i(clr),
        .y_o(y2), .match_count_o(cnt2), .count_sat_o(sat2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en, x, load, ov, clr;
        logic [3:0] pat;
        logic       y;
        int         c8, c2;
        logic       s2;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    task automatic add(input logic e, input logic xi, input logic ld, input logic [3:0] p,
                       input logic ov, input logic cl, input logic ey, input int ec8,
                       input int ec2, input logic es2);
        vec_t v;
        v.en = e; v.x = xi; v.load = ld; v.pat = p; v.ov = ov; v.clr = cl;
        v.y = ey; v.c8 = ec8; v.c2 = ec2; v.s2 = es2;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic run_vec(input int idx);
        vec_t v, e;
        v = vecs[idx];
        @(negedge clk);
        en = v.en; x = v.x; load = v.load; pattern = v.pat; overlap = v.ov; clr = v.clr;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check($sformatf("v%0d y", idx),     int'(y8),   int'(e.y));
        check($sformatf("v%0d cnt", idx),   int'(cnt8), e.c8);
        check($sformatf("v%0d sat", idx),   int'(sat8), 0);
        check($sformatf("v%0d y_w2", idx),  int'(y2),   int'(e.y));
        check($sformatf("v%0d cnt_w2", idx), int'(cnt2), e.c2);
        check($sformatf("v%0d sat_w2", idx), int'(sat2), int'(e.s2));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " y"},      int'(y8),   0);
        check({tag, " cnt"},    int'(cnt8), 0);
        check({tag, " sat"},    int'(sat8), 0);
        check({tag, " y_w2"},   int'(y2),   0);
        check({tag, " cnt_w2"}, int'(cnt2), 0);
        check({tag, " sat_w2"}, int'(sat2), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // en  x  ld pat      ov clr | y c8 c2 s2
        // default pattern 1011, overlapping
        add(1, 1, 0, 4'b0000, 1, 0,  0, 0, 0, 0);
        add(1, 0, 0, 4'b0000, 1, 0,  0, 0, 0, 0);
        add(1, 1, 0, 4'b0000, 1, 0,  0, 0, 0, 0);
        add(1, 1, 0, 4'b0000, 1, 0,  1, 1, 1, 0);
        add(1, 0, 0, 4'b0000, 1, 0,  0, 1, 1, 0);
        add(1, 1, 0, 4'b0000, 1, 0,  0, 1, 1, 0);
        add(1, 1, 0, 4'b0000, 1, 0,  1, 2, 2, 0);
        // load and clear together; X ignored
        add(1, 1, 1, 4'b1011, 1, 1,  0, 0, 0, 0);
        // same stream, non-overlapping
        add(1, 1, 0, 4'b0000, 0, 0,  0, 0, 0, 0);
        add(1, 0, 0, 4'b0000, 0, 0,  0, 0, 0, 0);
        add(1, 1, 0, 4'b0000, 0, 0,  0, 0, 0, 0);
        add(1, 1, 0, 4'b0000, 0, 0,  1, 1, 1, 0);
        add(1, 0, 0, 4'b0000, 0, 0,  0, 1, 1, 0);
        add(1, 1, 0, 4'b0000, 0, 0,  0, 1, 1, 0);
        add(1, 1, 0, 4'b0000, 0, 0,  0, 1, 1, 0);
        // pattern 0000, overlapping run of zeros; narrow counter saturates
        add(0, 0, 1, 4'b0000, 1, 0,  0, 1, 1, 0);
        add(1, 0, 0, 4'b0000, 1, 0,  0, 1, 1, 0);
        add(1, 0, 0, 4'b0000, 1, 0,  0, 1, 1, 0);
        add(1, 0, 0, 4'b0000, 1, 0,  0, 1, 1, 0);
        add(1, 0, 0, 4'b0000, 1, 0,  1, 2, 2, 0);
        add(1, 0, 0, 4'b0000, 1, 0,  1, 3, 3, 1);
        add(1, 0, 0, 4'b0000, 1, 0,  1, 4, 3, 1);
        // clear on a match edge: Y still pulses
        add(1, 0, 0, 4'b0000, 1, 1,  1, 0, 0, 0);
        // overlap dropped mid-run: this match restarts filling
        add(1, 0, 0, 4'b0000, 0, 0,  1, 1, 1, 0);
        add(1, 0, 0, 4'b0000, 0, 0,  0, 1, 1, 0);
        add(0, 0, 0, 4'b0000, 0, 0,  0, 1, 1, 0);
        // En gaps do not disturb history
        add(0, 0, 1, 4'b1011, 1, 0,  0, 1, 1, 0);
        add(1, 1, 0, 4'b0000, 1, 0,  0, 1, 1, 0);
        add(1, 0, 0, 4'b0000, 1, 0,  0, 1, 1, 0);
        add(1, 1, 0, 4'b0000, 1, 0,  0, 1, 1, 0);
        add(0, 0, 0, 4'b0000, 1, 0,  0, 1, 1, 0);
        add(0, 1, 0, 4'b0000, 1, 0,  0, 1, 1, 0);
        add(0, 0, 0, 4'b0000, 1, 0,  0, 1, 1, 0);
        add(1, 1, 0, 4'b0000, 1, 0,  1, 2, 2, 0);
        // load 0000 then partial 1,0,1 before the mid-pattern reset
        add(0, 0, 1, 4'b0000, 1, 0,  0, 2, 2, 0);
        add(1, 1, 0, 4'b0000, 1, 0,  0, 2, 2, 0);
        add(1, 0, 0, 4'b0000, 1, 0,  0, 2, 2, 0);
        add(1, 1, 0, 4'b0000, 1, 0,  0, 2, 2, 0);
        // after reset: pattern back to 1011, filling restarted
        add(1, 1, 0, 4'b0000, 1, 0,  0, 0, 0, 0);
        add(1, 0, 0, 4'b0000, 1, 0,  0, 0, 0, 0);
        add(1, 1, 0, 4'b0000, 1, 0,  0, 0, 0, 0);
        add(1, 1, 0, 4'b0000, 1, 0,  1, 1, 1, 0);

        rst_n = 1'b0; en = 1'b0; x = 1'b0; load = 1'b0; pattern = 4'b0000;
        overlap = 1'b1; clr = 1'b0;
        #2;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 38; i++) run_vec(i);

        // asynchronous reset mid-cycle, away from any clock edge
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        en = 1'b0; load = 1'b0; clr = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 38; i < vecs.size(); i++) run_vec(i);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
